// File: rtl/formation_pkg.sv
// Shared types and helpers for the enemy formation controller.
package formation_pkg;

  localparam int POS_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARCH,
    ST_DESCEND,
    ST_CLEARED,
    ST_INVADED
  } formation_state_t;

  function automatic logic [3:0] max_u4(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous frame_clk level into the pixel-clock domain and
// emits a registered one-cycle strobe on each rising edge.
module frame_tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_clk,
  output logic frame_tick
);

  logic [1:0] r_sync;
  logic       r_prev;
  logic       r_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], frame_clk};
      r_prev <= r_sync[1];
      r_tick <= r_sync[1] & ~r_prev;
    end
  end

  assign frame_tick = r_tick;

endmodule

// File: rtl/enemy_formation_ctrl.sv
// March/descend/wave-end controller for the enemy formation.
// Optional FORMATION_SPEEDUP_EN shortens the step period as enemies die.
module enemy_formation_ctrl
  import formation_pkg::*;
#(
  parameter int               NUM_ENEMIES = 8,
  parameter logic [POS_W-1:0] START_X     = 10'd40,
  parameter logic [POS_W-1:0] START_Y     = 10'd40,
  parameter logic [POS_W-1:0] FORM_WIDTH  = 10'd400,
  parameter logic [POS_W-1:0] LEFT_BOUND  = 10'd8,
  parameter logic [POS_W-1:0] RIGHT_BOUND = 10'd632,
  parameter logic [POS_W-1:0] STEP_DOWN   = 10'd16,
  parameter logic [POS_W-1:0] INVADE_Y    = 10'd400,
  parameter int               BASE_PERIOD = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_clk,
  input  logic             start,
  input  logic             enemy_hit,
  output logic [POS_W-1:0] formation_x,
  output logic [POS_W-1:0] formation_y,
  output logic             enemy_direction_X,
  output logic             enemy_direction_Y,
  output logic             step_pulse,
  output logic             is_playing,
  output logic             delete_enemies,
  output logic             wave_cleared,
  output logic             invaded,
  output logic [5:0]       alive_count
);

  localparam logic [3:0] BASE_P = 4'(BASE_PERIOD);
  localparam logic [5:0] NUM_E  = 6'(NUM_ENEMIES);

  formation_state_t r_state, w_state_nxt;
  logic [POS_W-1:0] r_x, w_x_nxt, r_y, w_y_nxt, r_desc_cnt, w_desc_cnt_nxt;
  logic             r_dir_x, w_dir_x_nxt, r_dir_y, w_dir_y_nxt;
  logic             r_step, w_step_nxt, r_delete, w_delete_nxt;
  logic [5:0]       r_alive, w_alive_nxt;
  logic [3:0]       r_frame_cnt, w_frame_cnt_nxt, r_period, w_period_nxt;
  logic [3:0]       w_period_target;
  logic [1:0]       r_rst_sync;
  logic             w_rst_n, w_frame_tick, w_wrap, w_bounce;
  logic [POS_W:0]   w_x_step, w_y_inc;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  frame_tick_sync u_frame_tick_sync (
    .clk        (Clk),
    .rst_n      (w_rst_n),
    .frame_clk  (frame_clk),
    .frame_tick (w_frame_tick)
  );

`ifdef FORMATION_SPEEDUP_EN
  always_comb begin
    w_period_target = BASE_P;
    if (r_alive <= (NUM_E >> 2))      w_period_target = 4'd1;
    else if (r_alive <= (NUM_E >> 1)) w_period_target = max_u4(4'd1, BASE_P >> 1);
  end
`else
  assign w_period_target = BASE_P;
`endif

  assign w_wrap   = w_frame_tick && (r_frame_cnt == r_period - 4'd1);
  assign w_x_step = r_dir_x ? ({1'b0, r_x} + 11'd1) : ({1'b0, r_x} - 11'd1);
  assign w_y_inc  = {1'b0, r_y} + 11'd1;
  assign w_bounce = r_dir_x ? ((w_x_step + {1'b0, FORM_WIDTH}) > {1'b0, RIGHT_BOUND})
                            : ((r_x == '0) || (w_x_step < {1'b0, LEFT_BOUND}));

  // NOTE: every always_comb target gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt     = r_state;
    w_x_nxt         = r_x;
    w_y_nxt         = r_y;
    w_dir_x_nxt     = r_dir_x;
    w_dir_y_nxt     = r_dir_y;
    w_alive_nxt     = r_alive;
    w_frame_cnt_nxt = r_frame_cnt;
    w_desc_cnt_nxt  = r_desc_cnt;
    w_period_nxt    = r_period;
    w_step_nxt      = 1'b0;
    w_delete_nxt    = 1'b0;
    case (r_state)
      ST_IDLE, ST_CLEARED, ST_INVADED: begin
        if (start) begin
          w_state_nxt     = ST_MARCH;
          w_x_nxt         = START_X;
          w_y_nxt         = START_Y;
          w_alive_nxt     = NUM_E;
          w_dir_x_nxt     = 1'b1;
          w_dir_y_nxt     = 1'b0;
          w_frame_cnt_nxt = '0;
          w_period_nxt    = BASE_P;
        end
      end
      ST_MARCH, ST_DESCEND: begin
        if (w_wrap) begin
          w_frame_cnt_nxt = '0;
          w_period_nxt    = w_period_target;
          if (r_state == ST_MARCH) begin
            if (w_bounce) begin
              w_state_nxt    = ST_DESCEND;
              w_dir_y_nxt    = 1'b1;
              w_desc_cnt_nxt = '0;
            end else begin
              w_x_nxt    = w_x_step[POS_W-1:0];
              w_step_nxt = 1'b1;
            end
          end else begin
            w_y_nxt        = w_y_inc[POS_W-1:0];
            w_step_nxt     = 1'b1;
            w_desc_cnt_nxt = r_desc_cnt + 1'b1;
            if (w_y_inc >= {1'b0, INVADE_Y}) begin
              w_state_nxt  = ST_INVADED;
              w_delete_nxt = 1'b1;
              w_dir_y_nxt  = 1'b0;
            end else if (({1'b0, r_desc_cnt} + 11'd1) == {1'b0, STEP_DOWN}) begin
              w_state_nxt = ST_MARCH;
              w_dir_y_nxt = 1'b0;
              w_dir_x_nxt = ~r_dir_x;
            end
          end
        end else if (w_frame_tick) begin
          w_frame_cnt_nxt = r_frame_cnt + 4'd1;
        end
        // Evaluated last so a clear overrides a same-cycle invasion.
        if (enemy_hit && (r_alive != '0)) begin
          w_alive_nxt = r_alive - 6'd1;
          if (r_alive == 6'd1) begin
            w_state_nxt  = ST_CLEARED;
            w_delete_nxt = 1'b1;
            w_dir_y_nxt  = 1'b0;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= ST_IDLE;
      r_x         <= START_X;
      r_y         <= START_Y;
      r_dir_x     <= 1'b0;
      r_dir_y     <= 1'b0;
      r_alive     <= '0;
      r_frame_cnt <= '0;
      r_desc_cnt  <= '0;
      r_period    <= BASE_P;
      r_step      <= 1'b0;
      r_delete    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_dir_x     <= w_dir_x_nxt;
      r_dir_y     <= w_dir_y_nxt;
      r_alive     <= w_alive_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_desc_cnt  <= w_desc_cnt_nxt;
      r_period    <= w_period_nxt;
      r_step      <= w_step_nxt;
      r_delete    <= w_delete_nxt;
    end
  end

  assign formation_x       = r_x;
  assign formation_y       = r_y;
  assign enemy_direction_X = r_dir_x;
  assign enemy_direction_Y = r_dir_y;
  assign step_pulse        = r_step;
  assign delete_enemies    = r_delete;
  assign alive_count       = r_alive;
  assign is_playing        = (r_state == ST_MARCH) || (r_state == ST_DESCEND);
  assign wave_cleared      = (r_state == ST_CLEARED);
  assign invaded           = (r_state == ST_INVADED);

endmodule

// File: tb/tb_enemy_formation_ctrl.sv
// Directed bench: three controller instances (default, bounce-ready, invade-ready)
// driven by one frame clock.
module tb_enemy_formation_ctrl;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic frame_clk = 1'b0;
  logic start = 1'b0;
  logic hit_a = 1'b0;

  logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
  logic a_dx, a_dy, a_step, a_play, a_del, a_clr, a_inv;
  logic b_dx, b_dy, b_step, b_play, b_del, b_clr, b_inv;
  logic c_dx, c_dy, c_step, c_play, c_del, c_clr, c_inv;
  logic [5:0] a_alive, b_alive, c_alive;

  int n_checks = 0;
  int n_pass   = 0;
  int steps_a = 0, steps_b = 0, del_a = 0, del_c = 0;
  int base;

  always #5 Clk = ~Clk;

  enemy_formation_ctrl dut_a (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start), .enemy_hit(hit_a),
    .formation_x(a_x), .formation_y(a_y), .enemy_direction_X(a_dx), .enemy_direction_Y(a_dy),
    .step_pulse(a_step), .is_playing(a_play), .delete_enemies(a_del), .wave_cleared(a_clr),
    .invaded(a_inv), .alive_count(a_alive)
  );

  enemy_formation_ctrl #(.START_X(10'd231)) dut_b (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start), .enemy_hit(1'b0),
    .formation_x(b_x), .formation_y(b_y), .enemy_direction_X(b_dx), .enemy_direction_Y(b_dy),
    .step_pulse(b_step), .is_playing(b_play), .delete_enemies(b_del), .wave_cleared(b_clr),
    .invaded(b_inv), .alive_count(b_alive)
  );

  enemy_formation_ctrl #(.START_X(10'd231), .START_Y(10'd399)) dut_c (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start), .enemy_hit(1'b0),
    .formation_x(c_x), .formation_y(c_y), .enemy_direction_X(c_dx), .enemy_direction_Y(c_dy),
    .step_pulse(c_step), .is_playing(c_play), .delete_enemies(c_del), .wave_cleared(c_clr),
    .invaded(c_inv), .alive_count(c_alive)
  );

  always @(negedge Clk) begin
    if (a_step) steps_a++;
    if (b_step) steps_b++;
    if (a_del)  del_a++;
    if (c_del)  del_c++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic do_tick();
    @(negedge Clk); frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  // Hit lands in the cycle the registered tick is consumed, i.e. with the step.
  task automatic tick_with_hit();
    @(negedge Clk); frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    hit_a = 1'b1;
    @(negedge Clk);
    hit_a = 1'b0; frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic hit_pulse();
    @(negedge Clk); hit_a = 1'b1;
    @(negedge Clk); hit_a = 1'b0;
  endtask

  task automatic do_start();
    @(negedge Clk); start = 1'b1;
    @(negedge Clk); start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk); Reset = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    repeat (4) @(negedge Clk);
  endtask

  typedef struct {
    int hits;
    int n_ticks;
    int exp_x;
    int exp_alive;
    int exp_steps;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{0, 0, 40, 8, 0};
    vecs[1] = '{0, 4, 41, 8, 1};
    vecs[2] = '{0, 4, 42, 8, 1};
    vecs[3] = '{2, 0, 42, 6, 0};
    vecs[4] = '{2, 4, 43, 4, 1};
`ifdef FORMATION_SPEEDUP_EN
    vecs[5] = '{0, 4, 45, 4, 2};
    vecs[6] = '{2, 4, 48, 2, 3};
    vecs[7] = '{0, 2, 50, 2, 2};
`else
    vecs[5] = '{0, 4, 44, 4, 1};
    vecs[6] = '{2, 4, 45, 2, 1};
    vecs[7] = '{0, 2, 45, 2, 0};
`endif

    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    repeat (4) @(negedge Clk);

    check("idle_x", a_x, 40);
    check("idle_y", a_y, 40);
    check("idle_dir_x", a_dx, 0);
    check("idle_dir_y", a_dy, 0);
    check("idle_playing", a_play, 0);
    check("idle_alive", a_alive, 0);
    check("idle_flags", {a_step, a_del, a_clr, a_inv}, 0);

    do_start();
    for (int i = 0; i < 8; i++) begin
      base = steps_a;
      for (int h = 0; h < vecs[i].hits; h++) hit_pulse();
      ticks(vecs[i].n_ticks);
      check($sformatf("vec%0d_x", i), a_x, vecs[i].exp_x);
      check($sformatf("vec%0d_alive", i), a_alive, vecs[i].exp_alive);
      check($sformatf("vec%0d_steps", i), steps_a - base, vecs[i].exp_steps);
      check($sformatf("vec%0d_playing", i), a_play, 1);
      check($sformatf("vec%0d_dir_x", i), a_dx, 1);
    end

    // Clear: last hit coincides with a step.
    hit_pulse();
    do_tick();
    base = del_a;
    tick_with_hit();
`ifdef FORMATION_SPEEDUP_EN
    check("clear_x", a_x, 52);
`else
    check("clear_x", a_x, 46);
`endif
    check("clear_alive", a_alive, 0);
    check("clear_cleared", a_clr, 1);
    check("clear_playing", a_play, 0);
    check("clear_invaded", a_inv, 0);
    check("clear_delete_cycles", del_a - base, 1);
    hit_pulse();
    check("clear_hit_ignored", a_alive, 0);

    // Bounce on dut_b, invasion on dut_c.
    do_reset();
    do_start();
    check("bounce_start_x", b_x, 231);
    check("invade_start_y", c_y, 399);
    ticks(4);
    check("bounce_step1_x", b_x, 232);
    ticks(4);
    check("bounce_hold_x", b_x, 232);
    check("bounce_dir_y", b_dy, 1);
    check("bounce_y", b_y, 40);
    check("invade_pre_flag", c_inv, 0);
    check("invade_pre_dir_y", c_dy, 1);
    base = del_c;
    ticks(4);
    check("invade_y", c_y, 400);
    check("invade_flag", c_inv, 1);
    check("invade_playing", c_play, 0);
    check("invade_delete_cycles", del_c - base, 1);
    check("descend_y1", b_y, 41);
    base = steps_b;
    ticks(56);
    check("descend_y15", b_y, 55);
    check("descend_dir_y15", b_dy, 1);
    ticks(4);
    check("descend_y16", b_y, 56);
    check("descend_end_dir_y", b_dy, 0);
    check("descend_end_dir_x", b_dx, 0);
    check("descend_steps", steps_b - base, 15);
    ticks(4);
    check("return_x", b_x, 231);

    // Mid-wave reset during DESCEND.
    do_reset();
    do_start();
    ticks(12);
    check("mid_pre_dir_y", b_dy, 1);
    check("mid_pre_y", b_y, 41);
    @(negedge Clk); Reset = 1'b0;
    #1;
    check("mid_rst_x", b_x, 231);
    check("mid_rst_y", b_y, 40);
    check("mid_rst_dirs", {b_dx, b_dy}, 0);
    check("mid_rst_playing", b_play, 0);
    check("mid_rst_alive", b_alive, 0);
    @(negedge Clk); Reset = 1'b1;
    repeat (4) @(negedge Clk);
    do_start();
    check("restart_x", b_x, 231);
    check("restart_y", b_y, 40);
    check("restart_playing", b_play, 1);
    check("restart_alive", b_alive, 8);
    check("restart_dir_x", b_dx, 1);
    check("restart_a_x", a_x, 40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/enemy_formation_ctrl.md
# enemy_formation_ctrl

- Upstream controller for the enemy sprite blocks (`enemy_medium` and siblings).
- Owns the formation's march state: left/right direction, step-down phase, formation offset, alive count and wave end.
- Drives the `enemy_direction_X`, `enemy_direction_Y`, `delete_enemies` and `is_playing` inputs of every enemy instance.
- Runs on the pixel clock `Clk`. Frame timing comes from the `frame_clk` level, synchronised internally.

## Interface

Parameters:
- NUM_ENEMIES, 8 — enemies in the wave (1–63).
- START_X, 10'd40 — formation left edge after `start`.
- START_Y, 10'd40 — formation top edge after `start`.
- FORM_WIDTH, 10'd400 — formation width in pixels.
- LEFT_BOUND, 10'd8 — leftmost legal left edge.
- RIGHT_BOUND, 10'd632 — rightmost legal right edge.
- STEP_DOWN, 10'd16 — rows descended per bounce.
- INVADE_Y, 10'd400 — top-edge Y at which the wave has invaded.
- BASE_PERIOD, 4 — frames per horizontal step (1–15).

Ports:
- Clk  in  1  — pixel clock; the only clock.
- Reset  in  1  — reset, asynchronous, active-low.
- frame_clk  in  1  — frame pulse level, asynchronous to `Clk`.
- start  in  1  — level; starts a wave from IDLE, CLEARED or INVADED.
- enemy_hit  in  1  — one-cycle pulse per enemy destroyed.
- formation_x  out  10  — current left edge.
- formation_y  out  10  — current top edge.
- enemy_direction_X  out  1  — 0 = left, 1 = right.
- enemy_direction_Y  out  1  — 1 while descending.
- step_pulse  out  1  — one cycle per formation move.
- is_playing  out  1  — high in MARCH or DESCEND.
- delete_enemies  out  1  — one-cycle pulse on wave end.
- wave_cleared  out  1  — level, high in CLEARED.
- invaded  out  1  — level, high in INVADED.
- alive_count  out  6  — enemies remaining.

## Operation

States: IDLE, MARCH, DESCEND, CLEARED, INVADED.

- **IDLE.** All outputs 0 except `formation_x = START_X` and `formation_y = START_Y`.
- **Wave start.** `start` = 1 in IDLE, CLEARED or INVADED goes to MARCH and loads:
  - `formation_x = START_X`, `formation_y = START_Y`
  - `alive_count = NUM_ENEMIES`
  - `enemy_direction_X = 1`
  - frame counter = 0
- **Frame tick.** One-cycle strobe on each rising edge of synchronised `frame_clk`. Each tick increments the frame counter.
- **MARCH step.** When the counter reaches `period - 1` it clears and the formation steps ±1 in X. `step_pulse` fires.
- **Bounce.** If the step would place the left edge below LEFT_BOUND, or the right edge (`formation_x + FORM_WIDTH`) above RIGHT_BOUND:
  - no X step is taken;
  - enter DESCEND, set `enemy_direction_Y = 1`, clear the descend counter.
- **DESCEND.** On each step boundary `formation_y` increments by 1 and `step_pulse` fires. After STEP_DOWN increments:
  - `enemy_direction_Y = 0`
  - toggle `enemy_direction_X`
  - return to MARCH
- **Invasion.** `formation_y >= INVADE_Y` is checked after each Y increment. When true: enter INVADED and pulse `delete_enemies`.
- **Hits.** `enemy_hit` in MARCH or DESCEND decrements `alive_count`, saturating at 0. When it reaches 0: enter CLEARED and pulse `delete_enemies`. `enemy_hit` is ignored in other states.
- **Simultaneous events.**
  - Hit and step in the same cycle: both apply.
  - Clear and invade in the same cycle: CLEARED wins.
- **Arithmetic.** All position arithmetic is 11-bit unsigned; there is no wrap. `period` defaults to BASE_PERIOD.

## Timing

- `frame_clk` passes a 2-FF synchroniser plus edge detect. The tick occurs 3 `Clk` cycles after the edge.
- A registered step appears on `formation_x`/`formation_y` on the cycle after the tick. `step_pulse` is aligned with the position update.
- `start` is sampled every cycle. MARCH is entered one cycle later.
- `delete_enemies` is high for exactly the first cycle of CLEARED or INVADED.
- `alive_count` updates one cycle after `enemy_hit`.
- Reset asserted at any time forces IDLE immediately and sets all registers to their IDLE values.
- Reset release is synchronised internally (assert async, deassert sync).

## Configuration

- **With `FORMATION_SPEEDUP_EN` defined:** `period` is recomputed on each `alive_count` change.
  - `alive_count <= NUM_ENEMIES/2` gives `period = max(1, BASE_PERIOD/2)`.
  - `alive_count <= NUM_ENEMIES/4` gives `period = 1`.
  - A change takes effect at the next counter wrap.
- **Without it:** `period = BASE_PERIOD` always.

## Structure

- Package `formation_pkg` holds:
  - the state enum `formation_state_t`;
  - `POS_W = 10`;
  - the `max_u4` helper function.
- Sub-module `frame_tick_sync` holds the 2-FF synchroniser and rising-edge detector. It outputs `frame_tick`.
- Parameters remain on `enemy_formation_ctrl`.

## Test plan

- **Start/march.** Reset, `start` pulse, 8 ticks at BASE_PERIOD = 4 → `formation_x` = 42, 2 `step_pulse`s, `enemy_direction_X` = 1.
- **Bounce.** Start with `START_X` = 231, FORM_WIDTH = 400 → after 1 step, DESCEND.
  - Then 16 Y steps take `formation_y` from 40 to 56.
  - Then `enemy_direction_X` = 0 and the next step gives `formation_x` = 231.
- **Clear.** 8 `enemy_hit` pulses, the last coinciding with a step → `alive_count` = 0, CLEARED, `delete_enemies` high for exactly 1 cycle, `formation_x` includes the step.
- **Invade.** `START_Y` = 399, force a bounce → first Y step gives `formation_y` = 400, INVADED, `invaded` = 1, `delete_enemies` pulse.
- **Speedup.** With `FORMATION_SPEEDUP_EN`, 4 hits → period = 2; 6 hits → period = 1. Without the macro, period stays 4.
- **Mid-wave reset.** Reset asserted during DESCEND → outputs return to IDLE values with no clock edge; after release, `start` restarts from `START_X`/`START_Y`.
